// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack toggle receiver.
// Holds the capture FSM encoding and the default synchroniser depth.
// No logic; imported by the receiver top.
package cdc_pkg;

  // Default number of synchroniser flops on the incoming request and payload.
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Capture FSM: wait for a request edge, let the payload settle one cycle,
  // then hold the word until the FIFO has room.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SETTLE     = 2'd1,
    ST_WAIT_SPACE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchroniser chain for a level signal or a held-stable bus.
// Latency: STAGES clock edges from i_d to o_q.
// No backpressure; samples every cycle.
module cdc_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the input through the chain; reset clears every stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/cdc_reqack_rx_fifo.sv
// Receive side of a 4-phase-free toggle req/ack CDC, feeding a small FIFO.
// Latency: word visible on m_valid SYNC_STAGES+2 edges after req_tog is first sampled.
// Backpressure: a full FIFO withholds ack_tog, stalling the sender until a pop.
module cdc_reqack_rx_fifo
  import cdc_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                       dst_clk,
  input  logic                       dst_rst,
  input  logic                       req_tog,
  input  logic [W-1:0]               bus,
  output logic                       ack_tog,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [W-1:0]               m_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       protocol_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Synchronised request level, one extra flop for edge detection.
  logic         w_req_sync;
  logic         r_req_last;
  logic         w_req_edge;
  logic [W-1:0] w_bus_sync;

  cap_state_t   r_state;
  cap_state_t   w_state_nxt;
  logic         w_push;
  logic         w_push_ok;
  logic         w_pop;
  logic         w_proto_hit;

  logic         r_ack;
  logic         r_err;
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  cdc_sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk (dst_clk),
    .i_rst (dst_rst),
    .i_d   (req_tog),
    .o_q   (w_req_sync)
  );

  // The payload is held stable by the sender, so plain flops are enough.
  cdc_sync_chain #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .i_clk (dst_clk),
    .i_rst (dst_rst),
    .i_d   (bus),
    .o_q   (w_bus_sync)
  );

  // Last flop of the request chain; its XOR with the previous stage marks a new request.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      r_req_last <= 1'b0;
    end else begin
      r_req_last <= w_req_sync;
    end
  end

  assign w_req_edge = w_req_sync ^ r_req_last;
  assign w_pop      = (r_count != '0) && m_ready;
  assign w_push_ok  = (r_count < FULL_CNT) || ((r_count == FULL_CNT) && w_pop);

  // Capture FSM state register.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, write strobe, and detection of a request arriving while busy.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_proto_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_edge) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_proto_hit = w_req_edge;
        if (w_push_ok) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        w_proto_hit = w_req_edge;
        if (w_push_ok) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Ack flips once per accepted word; protocol error is sticky until reset.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_ack <= ~r_ack;
      end
      if (w_proto_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage array is not reset; contents are only meaningful below fifo_count.
  always_ff @(posedge dst_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_bus_sync;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ack_tog      = r_ack;
  assign protocol_err = r_err;
  assign m_valid      = (r_count != '0);
  assign m_data       = r_mem[r_rd_ptr];
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_cdc_reqack_rx_fifo.sv
// Self-checking bench for cdc_reqack_rx_fifo: a default instance and a
// deeper/slower-sync instance, with popped words checked against a queue.
module tb_cdc_reqack_rx_fifo;

  logic       clk = 1'b0;
  logic       dst_rst;
  logic       req_tog, m_ready;
  logic [7:0] bus;
  logic       ack_tog, m_valid, protocol_err;
  logic [7:0] m_data;
  logic [2:0] fifo_count;

  logic       req2, m_ready2;
  logic [7:0] bus2;
  logic       ack2, mv2, err2;
  logic [7:0] md2;
  logic [3:0] cnt2;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];
  logic [7:0] exp_w;
  logic [7:0] exp_w2;

  typedef struct {
    logic [7:0] data;
    int         exp_lat;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  cdc_reqack_rx_fifo #(.W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .dst_clk      (clk),
    .dst_rst      (dst_rst),
    .req_tog      (req_tog),
    .bus          (bus),
    .ack_tog      (ack_tog),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .fifo_count   (fifo_count),
    .protocol_err (protocol_err)
  );

  cdc_reqack_rx_fifo #(.W(8), .DEPTH(8), .SYNC_STAGES(3)) dut2 (
    .dst_clk      (clk),
    .dst_rst      (dst_rst),
    .req_tog      (req2),
    .bus          (bus2),
    .ack_tog      (ack2),
    .m_valid      (mv2),
    .m_ready      (m_ready2),
    .m_data       (md2),
    .fifo_count   (cnt2),
    .protocol_err (err2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboards: compare each word the moment the consumer accepts it.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("pop_data", {24'd0, m_data}, {24'd0, exp_w});
      end
    end
  end

  always @(negedge clk) begin
    if (mv2 && m_ready2) begin
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop2_unexpected: got %0h expected none", md2);
      end else begin
        exp_w2 = exp_q2.pop_front();
        chk("pop2_data", {24'd0, md2}, {24'd0, exp_w2});
      end
    end
  end

  task automatic do_reset();
    dst_rst = 1'b1;
    req_tog = 1'b0; bus = 8'h00; m_ready = 1'b0;
    req2 = 1'b0; bus2 = 8'h00; m_ready2 = 1'b0;
    exp_q.delete();
    exp_q2.delete();
    repeat (2) @(posedge clk);
    #1;
    dst_rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bus = d;
    req_tog = ~req_tog;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (ack_tog !== req_tog && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, {31'd0, ack_tog}, {31'd0, req_tog});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    m_ready = 1'b0;
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic a0;
    int   v_edge, a_edge, n;

    vecs[0] = '{data: 8'hA5, exp_lat: 4, exp_cnt: 1};
    vecs[1] = '{data: 8'h00, exp_lat: 4, exp_cnt: 1};
    vecs[2] = '{data: 8'hFF, exp_lat: 4, exp_cnt: 1};
    vecs[3] = '{data: 8'h5A, exp_lat: 4, exp_cnt: 1};

    // Reset state, observed while reset is held.
    dst_rst = 1'b1;
    req_tog = 1'b0; bus = 8'h00; m_ready = 1'b0;
    req2 = 1'b0; bus2 = 8'h00; m_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_ack", {31'd0, ack_tog}, 0);
    chk("rst_err", {31'd0, protocol_err}, 0);
    dst_rst = 1'b0;

    // m_ready on an empty FIFO does nothing.
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("ready_empty_count", {29'd0, fifo_count}, 0);
    chk("ready_empty_valid", {31'd0, m_valid}, 0);

    // Single-word latency table on an empty FIFO.
    for (int i = 0; i < 4; i++) begin
      a0 = ack_tog;
      v_edge = 0;
      a_edge = 0;
      send(vecs[i].data);
      for (int e = 1; e <= 12; e++) begin
        @(posedge clk); #1;
        if (v_edge == 0 && m_valid) v_edge = e;
        if (a_edge == 0 && ack_tog !== a0) a_edge = e;
      end
      chk("lat_valid", v_edge, vecs[i].exp_lat);
      chk("lat_ack", a_edge, vecs[i].exp_lat);
      chk("lat_data", {24'd0, m_data}, {24'd0, vecs[i].data});
      chk("lat_count", {29'd0, fifo_count}, vecs[i].exp_cnt);
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk("lat_popped", {29'd0, fifo_count}, 0);
    end

    // Fill to full, fifth word stalls, one pop lets it in same cycle.
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      wait_ack("fill_ack");
    end
    chk("full_count", {29'd0, fifo_count}, 4);
    send(8'h05);
    repeat (12) @(posedge clk);
    #1;
    chk("ack_withheld", {31'd0, ack_tog}, {31'd0, ~req_tog});
    chk("full_hold_count", {29'd0, fifo_count}, 4);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("pop_push_ack", {31'd0, ack_tog}, {31'd0, req_tog});
    chk("pop_push_count", {29'd0, fifo_count}, 4);
    drain("drain_full");

    // Streaming with consumer always ready; wraps the pointers.
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(8'h10 + 8'(i));
      wait_ack("stream_ack");
    end
    drain("drain_stream");
    chk("stream_count", {29'd0, fifo_count}, 0);
    chk("stream_err", {31'd0, protocol_err}, 0);

    // Double toggle: error flagged, only one word taken and acked.
    a0 = ack_tog;
    send(8'h77);
    @(posedge clk); #1;
    req_tog = ~req_tog;
    repeat (12) @(posedge clk);
    #1;
    chk("dbl_err", {31'd0, protocol_err}, 1);
    chk("dbl_count", {29'd0, fifo_count}, 1);
    chk("dbl_ack_once", {31'd0, ack_tog}, {31'd0, ~a0});
    drain("drain_dbl");
    repeat (5) @(posedge clk);
    #1;
    chk("dbl_err_sticky", {31'd0, protocol_err}, 1);

    // Reset while in SETTLE drops the pending word with no ack.
    do_reset();
    send(8'h99);
    repeat (3) @(posedge clk);
    #1;
    dst_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_ack", {31'd0, ack_tog}, 0);
    chk("midrst_valid", {31'd0, m_valid}, 0);
    chk("midrst_count", {29'd0, fifo_count}, 0);
    chk("midrst_err", {31'd0, protocol_err}, 0);
    req_tog = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dst_rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_ghost", {29'd0, fifo_count}, 0);
    send(8'h42);
    wait_ack("after_rst_ack");
    chk("after_rst_count", {29'd0, fifo_count}, 1);
    drain("drain_after_rst");

    // A request level held high across reset counts as one new request.
    dst_rst = 1'b1;
    req_tog = 1'b1;
    bus = 8'h3C;
    exp_q.delete();
    exp_q.push_back(8'h3C);
    repeat (2) @(posedge clk);
    #1;
    dst_rst = 1'b0;
    wait_ack("held_req_ack");
    chk("held_req_count", {29'd0, fifo_count}, 1);
    drain("drain_held");

    // Deeper instance: three-stage sync latency and eight-entry stall point.
    do_reset();
    a0 = ack2;
    v_edge = 0;
    bus2 = 8'hC3;
    req2 = ~req2;
    exp_q2.push_back(8'hC3);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (v_edge == 0 && mv2) v_edge = e;
    end
    chk("lat2_valid", v_edge, 5);
    chk("lat2_ack", {31'd0, ack2}, {31'd0, ~a0});
    m_ready2 = 1'b1;
    @(posedge clk); #1;
    m_ready2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus2 = 8'h20 + 8'(i);
      req2 = ~req2;
      exp_q2.push_back(bus2);
      n = 0;
      while (ack2 !== req2 && n < 40) begin
        @(posedge clk); #1; n++;
      end
      if (i < 8) chk("fill2_ack", {31'd0, ack2}, {31'd0, req2});
    end
    chk("stall2_ack", {31'd0, ack2}, {31'd0, ~req2});
    chk("full2_count", {28'd0, cnt2}, 8);
    m_ready2 = 1'b1;
    n = 0;
    while (exp_q2.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    m_ready2 = 1'b0;
    chk("drain2_q", exp_q2.size(), 0);
    chk("drain2_ack", {31'd0, ack2}, {31'd0, req2});
    chk("drain2_count", {28'd0, cnt2}, 0);
    chk("drain2_err", {31'd0, err2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_reqack_rx_fifo.md
CDC_REQACK_RX_FIFO -- requirements
Module: cdc_reqack_rx_fifo

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: W, 8, payload width (>=1).
REQ-003 Parameter: DEPTH, 4, FIFO entries (power of two, >=2).
REQ-004 Parameter: SYNC_STAGES, 2, synchroniser flops on req_tog and bus (>=2).
REQ-005 dst_clk  in  1  receive-domain clock.
REQ-006 dst_rst  in  1  asynchronous active-high reset.
REQ-007 req_tog  in  1  sender request toggle, asynchronous to dst_clk.
REQ-008 bus  in  W  sender payload, held stable from req_tog toggle until ack_tog toggle.
REQ-009 ack_tog  out  1  acknowledge toggle returned to the sender.
REQ-010 m_valid  out  1  FIFO non-empty.
REQ-011 m_ready  in  1  consumer accepts m_data this cycle.
REQ-012 m_data  out  W  FIFO head word.
REQ-013 fifo_count  out  $clog2(DEPTH+1)  occupied entries.
REQ-014 protocol_err  out  1  sticky; sender toggled req_tog before the previous ack.

Function
REQ-015 req_tog SHALL pass through SYNC_STAGES+1 flops; req_edge = XOR of the last two.
REQ-016 bus SHALL pass through SYNC_STAGES flops (no per-bit edge logic); only the last stage is written to the FIFO.
REQ-017 Capture FSM states: IDLE, SETTLE, WAIT_SPACE.
REQ-018 IDLE: req_edge -> SETTLE next cycle.
REQ-019 SETTLE (one cycle): if push allowed, write the last bus stage, toggle ack_tog, go to IDLE; otherwise go to WAIT_SPACE.
REQ-020 WAIT_SPACE: hold; on the first cycle push is allowed, write the last bus stage, toggle ack_tog, go to IDLE.
REQ-021 Push is allowed when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs the same cycle.
REQ-022 ack_tog SHALL toggle only in a write cycle, exactly once per accepted word; a full FIFO stalls the sender by withholding ack.
REQ-023 Latency: on an empty FIFO, m_valid SHALL rise SYNC_STAGES+2 dst_clk edges after the first edge that samples the new req_tog.
REQ-024 Pop occurs when m_valid and m_ready; m_data = mem[rd_ptr], combinational from the storage array; m_data is don't-care when m_valid=0.
REQ-025 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; fifo_count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
REQ-026 m_ready with m_valid=0 SHALL have no effect.
REQ-027 A req_edge while the state is not IDLE SHALL set protocol_err and is otherwise ignored (no extra write, no ack).

Reset
REQ-028 dst_rst SHALL asynchronously clear: both sync chains, state=IDLE, pointers, fifo_count=0, m_valid=0, ack_tog=0, protocol_err=0.
REQ-029 Reset mid-transfer SHALL discard the pending word without toggling ack; FIFO contents are lost; storage array is not reset.
REQ-030 After reset release, a req_tog level differing from the reset value SHALL be treated as one new request (edge seen through the chain).

Structure
REQ-031 FSM state encodings and the default SYNC_STAGES SHALL live in shared package cdc_pkg.
REQ-032 The flop chain SHALL be sub-module cdc_sync_chain (params WIDTH, STAGES), instantiated for req_tog and bus.
REQ-033 Storage, pointers and count SHALL reside inline in this module; no other sub-modules.

Verification
REQ-034 W=8, DEPTH=4, SYNC_STAGES=2, empty FIFO: bus=0xA5, toggle req_tog -> m_valid=1 and m_data=0xA5 at edge 4, ack_tog toggles the same edge, fifo_count=1.
REQ-035 m_ready=0, send 0x01..0x05 with proper handshakes -> four acks, fifo_count=4, fifth ack withheld (WAIT_SPACE); one pop -> 0x05 written and acked that cycle, count stays 4.
REQ-036 Continuous m_ready=1, 10 back-to-back words 0x10..0x19 -> output order 0x10..0x19, no loss, pointer wrap exercised, protocol_err=0.
REQ-037 Toggle req_tog twice within 2 cycles -> protocol_err=1 (stays 1), exactly one word written, one ack toggle.
REQ-038 Assert dst_rst while in SETTLE -> all outputs 0, ack_tog unchanged from 0, fifo_count=0; next request completes normally.
REQ-039 SYNC_STAGES=3 -> single-word latency of 5 edges; DEPTH=8 -> eight words accepted before ack stalls.
